// File: rtl/spi_cfg_pkg.sv
// Shared types and default constants for the SPI slave configuration sequencer.
package spi_cfg_pkg;

  localparam int DEF_NUM_REGS  = 4;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_MAX_RETRY = 3;
  localparam int DEF_TIMEOUT   = 255;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_IDLE = 3'd1,
    WRITE     = 3'd2,
    WAIT_ACK  = 3'd3,
    DONE      = 3'd4,
    FAIL      = 3'd5
  } state_t;

  // Index width that never collapses to zero bits.
  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_slave_cfg_seq.sv
// Writes a captured table of configuration words to an SPI slave with per-word retry.
// Optional macro SPI_CFG_TIMEOUT_EN adds a response timeout that counts as a rejection.
module spi_slave_cfg_seq
  import spi_cfg_pkg::*;
#(
  parameter int NUM_REGS  = DEF_NUM_REGS,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_RETRY = DEF_MAX_RETRY,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [NUM_REGS*DATA_W-1:0]        cfg_table,
  input  logic                              slave_busy,
  output logic [DATA_W-1:0]                 reg_din,
  output logic                              reg_din_val,
  input  logic                              reg_ack,
  input  logic                              reg_err,
  output logic                              busy,
  output logic                              done,
  output logic                              fail,
  output logic [min1_clog2(NUM_REGS)-1:0]   fail_idx
);

  localparam int IDX_W   = min1_clog2(NUM_REGS);
  localparam int RETRY_W = min1_clog2(MAX_RETRY + 1);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_REGS - 1);
  localparam logic [IDX_W-1:0]   IDX_ONE   = IDX_W'(1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  localparam logic [RETRY_W-1:0] RETRY_ONE = RETRY_W'(1);

  state_t                     state;
  state_t                     next_state;
  logic [IDX_W-1:0]           idx;
  logic [RETRY_W-1:0]         retry;
  logic [NUM_REGS*DATA_W-1:0] shadow;
  logic                       resp_err;

`ifdef SPI_CFG_TIMEOUT_EN
  localparam int TMR_W = min1_clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

  logic [TMR_W-1:0] timer;
  logic             timeout_hit;

  // An ack arriving on the final cycle still wins over the timeout.
  assign timeout_hit = (state == WAIT_ACK) && (timer == TMR_LAST) && !reg_ack;
  assign resp_err    = reg_err | timeout_hit;

  // Response timer: cleared while strobing, counts every WAIT_ACK cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (state == WRITE) begin
      timer <= '0;
    end else if (state == WAIT_ACK) begin
      timer <= timer + TMR_ONE;
    end else begin
      timer <= timer;
    end
  end
`else
  assign resp_err = reg_err;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; reg_err has priority over reg_ack.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (start) next_state = WAIT_IDLE; else next_state = IDLE;
      WAIT_IDLE: if (!slave_busy) next_state = WRITE; else next_state = WAIT_IDLE;
      WRITE:     next_state = WAIT_ACK;
      WAIT_ACK: begin
        if (resp_err) begin
          if (retry < RETRY_MAX) next_state = WAIT_IDLE;
          else                   next_state = FAIL;
        end else if (reg_ack) begin
          if (idx == LAST_IDX) next_state = DONE;
          else                 next_state = WAIT_IDLE;
        end else begin
          next_state = WAIT_ACK;
        end
      end
      DONE:    next_state = IDLE;
      FAIL:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Registered outputs, word/retry bookkeeping and table capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_din     <= '0;
      reg_din_val <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      fail        <= 1'b0;
      fail_idx    <= '0;
      idx         <= '0;
      retry       <= '0;
      shadow      <= '0;
    end else begin
      busy        <= (next_state != IDLE);
      reg_din_val <= (next_state == WRITE);
      done        <= (next_state == DONE);
      fail        <= (next_state == FAIL);
      if (next_state == WRITE) begin
        reg_din <= shadow[idx*DATA_W +: DATA_W];
      end else begin
        reg_din <= reg_din;
      end
      case (state)
        IDLE: begin
          if (start) begin
            shadow <= cfg_table;
            idx    <= '0;
            retry  <= '0;
          end
        end
        WAIT_ACK: begin
          if (resp_err) begin
            if (retry < RETRY_MAX) retry    <= retry + RETRY_ONE;
            else                   fail_idx <= idx;
          end else if (reg_ack && (idx != LAST_IDX)) begin
            idx   <= idx + IDX_ONE;
            retry <= '0;
          end
        end
        default: begin
          idx <= idx;
        end
      endcase
    end
  end

endmodule

// File: doc/spi_slave_cfg_seq.md
SPI_SLAVE_CFG_SEQ -- requirements
Module: spi_slave_cfg_seq

Interface
REQ-001 SHALL have parameter NUM_REGS, default 4, number of configuration words written per sequence (1..16).
REQ-002 SHALL have parameter DATA_W, default 8, configuration word width.
REQ-003 SHALL have parameter MAX_RETRY, default 3, retries allowed per word after reg_err/timeout.
REQ-004 SHALL have parameter TIMEOUT, default 255, clk cycles waited for reg_ack/reg_err (used only with SPI_CFG_TIMEOUT_EN).
REQ-005 clk  in  1  single system clock, all logic on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 start  in  1  one-cycle request to program the slave.
REQ-008 cfg_table  in  NUM_REGS*DATA_W  words to write; word i at bits [i*DATA_W +: DATA_W].
REQ-009 slave_busy  in  1  spi_slave busy; no write issued while high.
REQ-010 reg_din  out  DATA_W  word to spi_slave configuration port.
REQ-011 reg_din_val  out  1  one-cycle write strobe.
REQ-012 reg_ack  in  1  spi_slave accepted word.
REQ-013 reg_err  in  1  spi_slave rejected word.
REQ-014 busy  out  1  sequence in progress.
REQ-015 done  out  1  one-cycle pulse, all words acknowledged.
REQ-016 fail  out  1  one-cycle pulse, retries exhausted.
REQ-017 fail_idx  out  $clog2(NUM_REGS) (min 1)  index of failing word, held until next start.

Function
REQ-018 SHALL implement states IDLE, WAIT_IDLE, WRITE, WAIT_ACK, DONE, FAIL.
REQ-019 IDLE: start=1 -> capture cfg_table into shadow registers, idx=0, retry=0, go WAIT_IDLE; busy=1 from next cycle.
REQ-020 start while busy=1 SHALL be ignored; shadow registers unchanged.
REQ-021 WAIT_IDLE: slave_busy=0 -> WRITE; otherwise stay.
REQ-022 WRITE: reg_din_val=1 for exactly one cycle, reg_din=shadow[idx]; -> WAIT_ACK.
REQ-023 reg_din SHALL hold shadow[idx] from WRITE until leaving WAIT_ACK; reg_ack/reg_err sampled only in WAIT_ACK.
REQ-024 WAIT_ACK, reg_ack=1, reg_err=0: idx==NUM_REGS-1 -> DONE; else idx++, retry=0, -> WAIT_IDLE.
REQ-025 WAIT_ACK, reg_err=1 (reg_ack ignored if both high): retry<MAX_RETRY -> retry++, -> WAIT_IDLE (same idx); else -> FAIL.
REQ-026 DONE: done=1 one cycle -> IDLE; busy=0 in IDLE.
REQ-027 FAIL: fail=1 one cycle, fail_idx=idx -> IDLE.
REQ-028 Minimum latency start to reg_din_val SHALL be 2 cycles (start cycle N, strobe cycle N+2) with slave_busy=0.
REQ-029 NUM_REGS=1: single word, ack goes directly to DONE.

Reset
REQ-030 rst=1 SHALL immediately force IDLE, reg_din_val=0, reg_din=0, busy=0, done=0, fail=0, fail_idx=0, idx=0, retry=0, shadow=0, timer=0.
REQ-031 rst mid-sequence SHALL abort without any further strobe; no done/fail pulse.

Configuration
REQ-032 Macro SPI_CFG_TIMEOUT_EN defined: counter cleared on WAIT_ACK entry, incremented per WAIT_ACK cycle; reaching TIMEOUT without ack/err treated exactly as reg_err.
REQ-033 Macro SPI_CFG_TIMEOUT_EN undefined: no counter logic; WAIT_ACK waits indefinitely.

Structure
REQ-034 Package spi_cfg_pkg SHALL hold state enum type and default constants (NUM_REGS, DATA_W, MAX_RETRY, TIMEOUT).
REQ-035 Single module; no sub-module (timer inline under macro).

Verification
REQ-036 NUM_REGS=4, table 0x11,0x22,0x33,0x44, ack one cycle after each strobe -> four strobes with those values in order, done pulse, busy falls next cycle.
REQ-037 slave_busy held high 10 cycles after start -> no strobe during those cycles; strobe cycle after slave_busy falls plus one.
REQ-038 reg_err on word 2 twice then ack -> word 2 (0x33) strobed three times, sequence completes with done.
REQ-039 reg_err on word 1 four times (MAX_RETRY=3) -> fail pulse, fail_idx=1, no write of word 2.
REQ-040 With SPI_CFG_TIMEOUT_EN, TIMEOUT=8, no response -> re-strobe after 8 WAIT_ACK cycles, fail after 4 strobes total.
REQ-041 rst asserted in WAIT_ACK of word 2, start during busy -> outputs at reset values immediately; ignored start causes no shadow change.
